// File: rtl/uart_pattern_pkg.sv
// Shared types and helpers for the UART pattern generator.
package uart_pattern_pkg;

  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [1:0] {
    UART_PAR_NONE = 2'b00,
    UART_PAR_EVEN = 2'b01,
    UART_PAR_ODD  = 2'b10
  } uart_par_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 2-bit data-bits code (00=5 .. 11=8) to a bit count, clamped to max_bits.
  function automatic int unsigned decode_data_bits(input logic [1:0] code,
                                                   input int unsigned max_bits);
    int unsigned n;
    n = 32'd5 + 32'(code);
    if (n > max_bits) n = max_bits;
    return n;
  endfunction

  // Code 11 is treated like 00 (no parity).
  function automatic uart_par_e decode_parity(input logic [1:0] code);
    case (code)
      2'b01:   return UART_PAR_EVEN;
      2'b10:   return UART_PAR_ODD;
      default: return UART_PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-frame UART serializer: bit timer, shift register, parity and
// frame FSM. A new frame is accepted in IDLE or on the final stop-bit cycle,
// so consecutive frames go out with no idle gap.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for frame_valid_i
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting data bits out LSB first
// ST_PARITY | driving the parity bit
// ST_STOP   | driving one or two stop bits (1)
module uart_tx_core
  import uart_pattern_pkg::*;
#(
  parameter int DIV_WIDTH     = 16,
  parameter int MAX_DATA_BITS = 8,
  parameter int NB_W          = $clog2(MAX_DATA_BITS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DIV_WIDTH-1:0]     div_i,
  input  logic [NB_W-1:0]          nbits_i,
  input  uart_par_e                parity_i,
  input  logic                     stop2_i,
  input  logic                     frame_valid_i,
  input  logic [MAX_DATA_BITS-1:0] data_i,
  output logic                     frame_ready_o,
  output logic                     frame_end_o,
  output logic                     busy_o,
  output logic                     tx_o
);

  uart_state_e              state, state_nxt;
  logic [DIV_WIDTH-1:0]     bit_cnt;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic [MAX_DATA_BITS-1:0] mask;
  logic [NB_W-1:0]          bits_left;
  logic                     par_bit;
  logic                     last_stop;
  logic                     bit_end;
  logic                     load;

  assign busy_o        = (state != ST_IDLE);
  assign bit_end       = busy_o && (bit_cnt == '0);
  assign frame_end_o   = (state == ST_STOP) && bit_end && last_stop;
  assign frame_ready_o = (state == ST_IDLE) || frame_end_o;
  assign load          = frame_valid_i && frame_ready_o;

  // Keep only the low N data bits so parity and shifting ignore the rest.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) mask[i] = (NB_W'(i) < nbits_i);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_valid_i) state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = ST_DATA;
      ST_DATA:   if (bit_end && bits_left == NB_W'(1))
                   state_nxt = (parity_i == UART_PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (frame_end_o) state_nxt = frame_valid_i ? ST_START : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Serial line level for the current state.
  always_comb begin
    tx_o = UART_IDLE_LVL;
    case (state)
      ST_START:  tx_o = 1'b0;
      ST_DATA:   tx_o = shreg[0];
      ST_PARITY: tx_o = par_bit;
      default:   tx_o = UART_IDLE_LVL;
    endcase
  end

  // Bit timer, shift register, parity and stop-bit tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      bits_left <= '0;
      par_bit   <= 1'b0;
      last_stop <= 1'b0;
    end else if (load) begin
      bit_cnt   <= div_i;
      shreg     <= data_i & mask;
      bits_left <= nbits_i;
      par_bit   <= (^(data_i & mask)) ^ (parity_i == UART_PAR_ODD);
      last_stop <= ~stop2_i;
    end else if (busy_o) begin
      bit_cnt <= bit_end ? div_i : bit_cnt - DIV_WIDTH'(1);
      if (bit_end && state == ST_DATA) begin
        shreg     <= shreg >> 1;
        bits_left <= bits_left - NB_W'(1);
      end
      if (bit_end && state == ST_STOP) last_stop <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_pattern_tx.sv
// UART pattern generator: latches configuration on start, feeds an
// arithmetic byte sequence into the serializer, counts frames and ends the
// burst on frame count or a pending stop request.
module uart_pattern_tx
  import uart_pattern_pkg::*;
#(
  parameter int DIV_WIDTH     = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int MAX_DATA_BITS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [DIV_WIDTH-1:0]     div_i,
  input  logic [1:0]               data_bits_i,
  input  logic [1:0]               parity_i,
  input  logic                     stop2_i,
  input  logic [MAX_DATA_BITS-1:0] base_i,
  input  logic [MAX_DATA_BITS-1:0] step_i,
  input  logic [CNT_WIDTH-1:0]     count_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CNT_WIDTH-1:0]     frame_cnt_o
);

  localparam int NB_W = $clog2(MAX_DATA_BITS + 1);

  logic [DIV_WIDTH-1:0]     div_q;
  logic [NB_W-1:0]          nbits_q;
  uart_par_e                par_q;
  logic                     stop2_q;
  logic [MAX_DATA_BITS-1:0] step_q;
  logic [CNT_WIDTH-1:0]     count_q;
  logic [MAX_DATA_BITS-1:0] value;
  logic [CNT_WIDTH-1:0]     frame_cnt;
  logic                     active;
  logic                     stop_pend;
  logic                     done;
  logic                     accept;
  logic                     frame_valid;
  logic                     frame_ready;
  logic                     frame_end;
  logic                     core_busy;
  logic                     last_frame;
  logic                     burst_end;

  // active spans from the accepting edge to burst end, one cycle longer at
  // the front than busy_o, so a start pulse is never accepted twice.
  assign accept      = start_i && !active;
  assign last_frame  = (count_q != '0) && ((frame_cnt + CNT_WIDTH'(1)) == count_q);
  assign burst_end   = frame_end && (last_frame || stop_pend || stop_i);
  assign frame_valid = active && !burst_end;

  assign busy_o      = core_busy;
  assign done_o      = done;
  assign frame_cnt_o = frame_cnt;

  // Configuration captured only at an accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      nbits_q <= '0;
      par_q   <= UART_PAR_NONE;
      stop2_q <= 1'b0;
      step_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      div_q   <= div_i;
      nbits_q <= NB_W'(decode_data_bits(data_bits_i, MAX_DATA_BITS));
      par_q   <= decode_parity(parity_i);
      stop2_q <= stop2_i;
      step_q  <= step_i;
      count_q <= count_i;
    end
  end

  // Value sequence advances each time the serializer takes a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            value <= '0;
    else if (accept)                      value <= base_i;
    else if (frame_valid && frame_ready)  value <= value + step_q;
  end

  // Burst control: active flag, sticky stop, frame counter and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active    <= 1'b0;
      stop_pend <= 1'b0;
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= burst_end;
      if (accept) begin
        active    <= 1'b1;
        stop_pend <= 1'b0;
        frame_cnt <= '0;
      end else begin
        if (frame_end) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
        if (burst_end) begin
          active    <= 1'b0;
          stop_pend <= 1'b0;
        end else if (stop_i && core_busy) begin
          stop_pend <= 1'b1;
        end
      end
    end
  end

  uart_tx_core #(
    .DIV_WIDTH     (DIV_WIDTH),
    .MAX_DATA_BITS (MAX_DATA_BITS)
  ) u_core (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .div_i         (div_q),
    .nbits_i       (nbits_q),
    .parity_i      (par_q),
    .stop2_i       (stop2_q),
    .frame_valid_i (frame_valid),
    .data_i        (value),
    .frame_ready_o (frame_ready),
    .frame_end_o   (frame_end),
    .busy_o        (core_busy),
    .tx_o          (tx_o)
  );

endmodule

// File: tb/tb_uart_pattern_tx.sv
// Bench for uart_pattern_tx: directed table plus randomized bursts, each
// compared cycle by cycle against a waveform built from the frame rules.
module tb_uart_pattern_tx;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i, stop_i, stop2_i;
  logic [DW-1:0] div_i;
  logic [1:0]    data_bits_i, parity_i;
  logic [7:0]    base_i, step_i;
  logic [CW-1:0] count_i;
  logic          tx_o, busy_o, done_o;
  logic [CW-1:0] frame_cnt_o;

  typedef struct {
    int div; int dbits; int par; int stop2; int base; int step; int count;
    int stop_at; int stop_on_start; int exp_frames; int exp_len;
  } vec_t;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_pattern_tx #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .MAX_DATA_BITS(MAXB)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .div_i(div_i), .data_bits_i(data_bits_i), .parity_i(parity_i),
    .stop2_i(stop2_i), .base_i(base_i), .step_i(step_i), .count_i(count_i),
    .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nbits_of(vec_t v);
    int n;
    n = 5 + v.dbits;
    if (n > MAXB) n = MAXB;
    return n;
  endfunction

  function automatic int frame_len(vec_t v);
    int bits;
    bits = 1 + nbits_of(v) + ((v.par == 1 || v.par == 2) ? 1 : 0) + (v.stop2 != 0 ? 2 : 1);
    return bits * (v.div + 1);
  endfunction

  // Frames a burst should send: count limit, or the frame holding the stop.
  function automatic int model_frames(vec_t v);
    int fs;
    fs = (v.stop_at >= 0) ? (v.stop_at / frame_len(v) + 1) : 0;
    if (v.count == 0) return fs;
    if (v.stop_at >= 0 && fs < v.count) return fs;
    return v.count;
  endfunction

  function automatic void add_bits(bit b, int reps);
    for (int r = 0; r < reps; r++) exp_q.push_back(b);
  endfunction

  // Expected line level per clock cycle for the whole burst.
  function automatic void build_wave(vec_t v, int frames);
    int n, val, reps;
    bit p, bv;
    exp_q.delete();
    n    = nbits_of(v);
    reps = v.div + 1;
    for (int f = 0; f < frames; f++) begin
      val = (v.base + f * v.step) % 256;
      add_bits(1'b0, reps);
      p = 1'b0;
      for (int b = 0; b < n; b++) begin
        bv = ((val >> b) & 1) != 0;
        add_bits(bv, reps);
        p = p ^ bv;
      end
      if (v.par == 1) add_bits(p, reps);
      if (v.par == 2) add_bits(!p, reps);
      add_bits(1'b1, reps);
      if (v.stop2 != 0) add_bits(1'b1, reps);
    end
  endfunction

  task automatic scramble_cfg();
    div_i       = DW'($urandom_range(0, 7));
    data_bits_i = 2'($urandom);
    parity_i    = 2'($urandom);
    stop2_i     = 1'($urandom);
    base_i      = 8'($urandom);
    step_i      = 8'($urandom);
    count_i     = CW'($urandom_range(0, 3));
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int frames, exp_frames, exp_len, mism, done_at;
    frames = model_frames(v);
    build_wave(v, frames);
    exp_frames = (v.exp_frames >= 0) ? v.exp_frames : frames;
    exp_len    = (v.exp_len >= 0) ? v.exp_len : exp_q.size();
    if (v.stop_on_start != 0) begin
      stop_i = 1'b1;
      @(posedge clk); #1;
    end
    div_i = DW'(v.div); data_bits_i = 2'(v.dbits); parity_i = 2'(v.par);
    stop2_i = 1'(v.stop2); base_i = 8'(v.base); step_i = 8'(v.step);
    count_i = CW'(v.count);
    start_i = 1'b1;
    stop_i  = (v.stop_on_start != 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    check({tag, " busy_before_start_bit"}, int'(busy_o), 0);
    scramble_cfg();
    mism = 0;
    done_at = -1;
    for (int c = 0; c < exp_len + 20; c++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        done_at = c;
        break;
      end
      if (c >= exp_q.size() || tx_o !== exp_q[c] || busy_o !== 1'b1) begin
        if (mism == 0) $display("  %s first wave difference at cycle %0d", tag, c);
        mism++;
      end
      scramble_cfg();
      start_i = ($urandom_range(0, 3) == 0);
      stop_i  = (c == v.stop_at);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    check({tag, " done_cycle"}, done_at, exp_len);
    check({tag, " wave_errors"}, mism, 0);
    check({tag, " frame_cnt"}, int'(frame_cnt_o), exp_frames);
    check({tag, " busy_at_done"}, int'(busy_o), 0);
    check({tag, " tx_at_done"}, int'(tx_o), 1);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(done_o), 0);
  endtask

  vec_t vecs[6];
  vec_t rv;
  int   idle_bad;

  initial begin
    vecs[0] = '{div:3, dbits:3, par:0, stop2:0, base:'h41, step:1, count:10,
                stop_at:-1, stop_on_start:0, exp_frames:10, exp_len:400};
    vecs[1] = '{div:0, dbits:2, par:1, stop2:1, base:'h7F, step:1, count:2,
                stop_at:-1, stop_on_start:0, exp_frames:2, exp_len:22};
    vecs[2] = '{div:2, dbits:0, par:2, stop2:0, base:'h1F, step:0, count:1,
                stop_at:-1, stop_on_start:0, exp_frames:1, exp_len:24};
    vecs[3] = '{div:1, dbits:3, par:0, stop2:0, base:'h30, step:3, count:0,
                stop_at:50, stop_on_start:0, exp_frames:3, exp_len:60};
    vecs[4] = '{div:0, dbits:3, par:0, stop2:0, base:'hC3, step:'h81, count:2,
                stop_at:19, stop_on_start:0, exp_frames:2, exp_len:20};
    vecs[5] = '{div:0, dbits:1, par:3, stop2:1, base:'hA5, step:'h11, count:3,
                stop_at:-1, stop_on_start:1, exp_frames:3, exp_len:27};

    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; stop2_i = 1'b0;
    div_i = '0; data_bits_i = '0; parity_i = '0; base_i = '0; step_i = '0;
    count_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", int'(tx_o), 1);
    check("reset busy", int'(busy_o), 0);
    check("reset done", int'(done_o), 0);
    check("reset frame_cnt", int'(frame_cnt_o), 0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a data bit of the second frame (data all zero).
    div_i = '0; data_bits_i = 2'b11; parity_i = 2'b00; stop2_i = 1'b0;
    base_i = 8'h00; step_i = 8'h00; count_i = CW'(5);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("pre_reset tx low", int'(tx_o), 0);
    check("pre_reset frame_cnt", int'(frame_cnt_o), 1);
    rst_i = 1'b1;
    #1;
    check("async_reset tx", int'(tx_o), 1);
    check("async_reset busy", int'(busy_o), 0);
    check("async_reset frame_cnt", int'(frame_cnt_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle_bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) idle_bad++;
    end
    check("post_reset idle", idle_bad, 0);

    for (int i = 0; i < 8; i++) begin
      rv.div = $urandom_range(0, 3);   rv.dbits = $urandom_range(0, 3);
      rv.par = $urandom_range(0, 3);   rv.stop2 = $urandom_range(0, 1);
      rv.base = $urandom_range(0, 255); rv.step = $urandom_range(0, 255);
      rv.count = $urandom_range(0, 4);
      rv.stop_on_start = 0; rv.exp_frames = -1; rv.exp_len = -1;
      if (rv.count == 0 || $urandom_range(0, 2) == 0)
        rv.stop_at = $urandom_range(0, frame_len(rv) * ((rv.count == 0) ? 4 : rv.count) - 1);
      else
        rv.stop_at = -1;
      run_burst(rv, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
